// File: rtl/dmem_handshake_responder_if.sv
// Request/acknowledge bus between a CPU data port (master) and the data
// memory responder (slave).
//
// Handshake: the master raises req together with we/addr/wdata and holds
// them until it sees ack. The slave samples the request once, in IDLE, and
// ignores further changes. It answers with a single-cycle ack; rdata and
// err are meaningful only in that cycle, rdata then holds and err returns
// to 0. A req still high in the cycle after ack is a new request.
interface dmem_handshake_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/dmem_handshake_responder.sv
// Word-addressed data memory answering load/store requests with a
// programmable number of wait states. Misaligned or out-of-range accesses
// complete with err=1 and leave the RAM untouched.
module dmem_handshake_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dmem_handshake_responder_if.slave   bus,
    output logic [1:0]                  dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;
    logic        busy_q,  busy_d;
    logic [31:0] rdata_q, rdata_d;

    // Storage is not touched by reset; contents start at zero.
    logic [31:0] ram [DEPTH] = '{default: 32'h0};

    logic          acc_err;
    logic          ram_we;
    logic [AW-1:0] word_idx;

    // Only addr_q[31:2] selects the word; anything past DEPTH is rejected,
    // never folded back onto a lower word.
    assign word_idx = addr_q[AW+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.req) begin
                    addr_d  = bus.addr;
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(LATENCY);
                    busy_d  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The access itself happens on the edge that enters RESP.
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                    if (acc_err) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (we_q) begin
                        ram_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = ram[word_idx];
                    end
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM write port; ram_we can only be high in BUSY, so an asserted reset
    // (which forces IDLE) drops any pending store.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[word_idx] <= wdata_q;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_handshake_responder.sv
// Directed bench for dmem_handshake_responder: one instance with LATENCY=2
// and one with LATENCY=0, driven and sampled on the falling clock edge.
module tb_dmem_handshake_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_l2;
    logic [1:0] dbg_l0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_handshake_responder_if bus_l2 ();
    dmem_handshake_responder_if bus_l0 ();

    dmem_handshake_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_l2.slave),
        .dbg_state (dbg_l2)
    );

    dmem_handshake_responder #(.DEPTH(64), .LATENCY(0)) u_dut_l0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_l0.slave),
        .dbg_state (dbg_l0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit l0, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (l0) begin
            bus_l0.req = req; bus_l0.we = we; bus_l0.addr = addr; bus_l0.wdata = wdata;
        end else begin
            bus_l2.req = req; bus_l2.we = we; bus_l2.addr = addr; bus_l2.wdata = wdata;
        end
    endtask

    task automatic sample(input bit l0, output logic a, output logic e, output logic b,
                          output logic [31:0] r);
        if (l0) begin
            a = bus_l0.ack; e = bus_l0.err; b = bus_l0.busy; r = bus_l0.rdata;
        end else begin
            a = bus_l2.ack; e = bus_l2.err; b = bus_l2.busy; r = bus_l2.rdata;
        end
    endtask

    // One complete access with req held until ack; checks latency, result,
    // busy width and the quiet cycle after ack.
    task automatic access(input bit l0, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        int          cyc    = 0;
        int          busy_n = 0;
        bit          got    = 0;
        logic        a, e, b;
        logic [31:0] r;
        @(negedge clk);
        drive(l0, 1'b1, we, addr, wdata);
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            sample(l0, a, e, b, r);
            if (b) busy_n++;
            if (a) got = 1;
        end
        drive(l0, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!got) begin
            check({tag, " ack_timeout"}, 32'(got), 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(cyc - 1), l0 ? 32'd1 : 32'd3);
        check({tag, " rdata"}, r, exp_rdata);
        check({tag, " err"}, 32'(e), 32'(exp_err));
        @(negedge clk);
        sample(l0, a, e, b, r);
        check({tag, " ack_width"}, 32'(a), 32'd0);
        check({tag, " err_after"}, 32'(e), 32'd0);
        check({tag, " busy_after"}, 32'(b), 32'd0);
        check({tag, " rdata_hold"}, r, exp_rdata);
        check({tag, " busy_cycles"}, 32'(busy_n), l0 ? 32'd2 : 32'd4);
    endtask

    // Stop a hung run while still reporting it.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a, e, b;
        logic [31:0] r;
        int          ack_pos  [4];
        int          rise_pos [4];
        int          n_ack  = 0;
        int          n_rise = 0;
        logic        prev_b = 1'b0;
        bit          got    = 0;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'h1111_1111, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_00FC, 32'h6363_6363, 32'h6363_6363, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0006, 32'hAAAA_5555, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0100, 32'hBBBB_0000, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0108, 32'h7777_7777, 32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFC, 32'h9999_9999, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h6363_6363, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0101, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};

        // Clock/reset.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sample(1'b0, a, e, b, r);
        check("rst l2 ack", 32'(a), 32'd0);
        check("rst l2 err", 32'(e), 32'd0);
        check("rst l2 busy", 32'(b), 32'd0);
        check("rst l2 rdata", r, 32'h0);
        check("rst l2 state", 32'(dbg_l2), 32'd0);
        sample(1'b1, a, e, b, r);
        check("rst l0 ack", 32'(a), 32'd0);
        check("rst l0 busy", 32'(b), 32'd0);
        check("rst l0 state", 32'(dbg_l0), 32'd0);
        rst_n = 1'b1;

        // Table of single accesses, LATENCY=2.
        for (int i = 0; i < 13; i++) begin
            access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // LATENCY=0 store then load.
        access(1'b1, 1'b1, 32'h0, 32'h5, 32'h5, 1'b0, "l0 store");
        access(1'b1, 1'b0, 32'h0, 32'h0, 32'h5, 1'b0, "l0 load");

        // req held high for three back-to-back loads of address 8.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sample(1'b0, a, e, b, r);
            if (b && !prev_b) begin
                if (n_rise < 4) rise_pos[n_rise] = k;
                n_rise++;
            end
            prev_b = b;
            if (a) begin
                if (n_ack < 4) ack_pos[n_ack] = k;
                n_ack++;
                check($sformatf("b2b rdata%0d", n_ack), r, 32'hDEAD_BEEF);
                if (n_ack == 3) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        check("b2b ack_count", 32'(n_ack), 32'd3);
        check("b2b capture_count", 32'(n_rise), 32'd3);
        if (n_ack >= 3) begin
            check("b2b ack0", 32'(ack_pos[0]), 32'd4);
            check("b2b ack1", 32'(ack_pos[1]), 32'd9);
            check("b2b ack2", 32'(ack_pos[2]), 32'd14);
        end
        if (n_rise >= 3) begin
            check("b2b cap0", 32'(rise_pos[0]), 32'd1);
            check("b2b cap1", 32'(rise_pos[1]), 32'd6);
            check("b2b cap2", 32'(rise_pos[2]), 32'd11);
        end

        // Reset while a store to address 12 is in BUSY.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'hC, 32'h1234);
        @(negedge clk);
        @(negedge clk);
        sample(1'b0, a, e, b, r);
        check("midrst busy_before", 32'(b), 32'd1);
        check("midrst rdata_before", r, 32'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        sample(1'b0, a, e, b, r);
        check("midrst ack", 32'(a), 32'd0);
        check("midrst err", 32'(e), 32'd0);
        check("midrst busy", 32'(b), 32'd0);
        check("midrst rdata", r, 32'h0);
        check("midrst state", 32'(dbg_l2), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, "midrst load12");
        access(1'b0, 1'b1, 32'hC, 32'h5678, 32'h5678, 1'b0, "postrst store12");
        access(1'b0, 1'b0, 32'hC, 32'h0, 32'h5678, 1'b0, "postrst load12");

        // Inputs wander during BUSY; the captured request must win.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
        got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            sample(1'b0, a, e, b, r);
            if (a) begin
                got = 1;
            end else begin
                drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), (c % 2) ? 32'h14 : 32'h18, $urandom);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wander ack_seen", 32'(got), 32'd1);
        check("wander rdata", r, 32'hCAFE_F00D);
        check("wander err", 32'(e), 32'd0);
        @(negedge clk);
        access(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, "wander load16");
        access(1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, "wander load20");
        access(1'b0, 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, "wander load24");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
